// File: rtl/imem_loader.sv
// Instruction-memory program loader: accepts a checksummed byte-stream image,
// writes it word by word, and holds the core in reset until the image verifies.
module imem_loader #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is decoded from the registered state only, never from in_valid.

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_CSUM = 3'd3,
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [8:0]      DEPTH = 9'(1 << ADDR_W);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        xor_acc;
  logic [7:0]        hi_byte;

  logic accept;
  logic hdr_bad;
  logic last_word;

  assign in_ready  = (state == S_HDR) || (state == S_HI) ||
                     (state == S_LO)  || (state == S_CSUM);
  assign accept    = in_valid && in_ready;
  assign hdr_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH);
  assign last_word = ({1'b0, addr} == (count - ONE));
  assign dbg_state = state;

  // Status outputs are updated on the same edge as the state they describe,
  // so they always reflect the registered state one cycle after the cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HDR;
      count      <= '0;
      addr       <= '0;
      xor_acc    <= '0;
      hi_byte    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_HDR: begin
          if (accept) begin
            if (hdr_bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              count   <= in_data[ADDR_W:0];
              addr    <= '0;
              xor_acc <= in_data;
              state   <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            xor_acc <= xor_acc ^ in_data;
            state   <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            wr_data <= {hi_byte, in_data};
            wr_addr <= addr;
            wr_en   <= 1'b1;
            xor_acc <= xor_acc ^ in_data;
            if (last_word) begin
              state <= S_CSUM;
            end else begin
              addr  <= addr + 1'b1;
              state <= S_HI;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            // Words already written stay in memory on a mismatch.
            if (in_data == xor_acc) begin
              state      <= S_RUN;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (reload) begin
            state      <= S_HDR;
            done       <= 1'b0;
            core_reset <= 1'b1;
          end
        end
        S_ERR: begin
          // Sticky until reset; reload is deliberately ignored here.
          state <= S_ERR;
        end
        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized images checked
// against a byte-list reference model and a write-strobe scoreboard.
module tb_imem_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WW     = ADDR_W + 16;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              core_reset;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [WW-1:0] exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_reset(core_reset), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr,data}
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {12'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      end else begin
        chk("write", {12'd0, wr_addr, wr_data}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  // Reference model: parses the byte list as the image format describes.
  // outcome: 0 = incomplete (still loading), 1 = verified/run, 2 = error.
  task automatic model_image(input logic [7:0] b[$], output int consumed, output int outcome);
    int h;
    logic [7:0] x;
    consumed = 0;
    outcome  = 0;
    if (b.size() == 0) return;
    h = b[0];
    if (h == 0 || h > DEPTH) begin
      consumed = 1;
      outcome  = 2;
      return;
    end
    for (int w = 0; w < h; w++)
      if (2 + 2 * w < b.size())
        exp_q.push_back({ADDR_W'(w), b[1 + 2 * w], b[2 + 2 * w]});
    consumed = (b.size() < 2 * h + 2) ? b.size() : 2 * h + 2;
    if (b.size() >= 2 * h + 2) begin
      x = 8'd0;
      for (int i = 0; i <= 2 * h; i++) x ^= b[i];
      outcome = (x == b[2 * h + 1]) ? 1 : 2;
    end
  endtask

  // driver: called and returns at a negedge; stops once the loader refuses bytes
  task automatic drive(input logic [7:0] b[$], input int gap_min, input int gap_max,
                       output int consumed);
    int g;
    consumed = 0;
    foreach (b[i]) begin
      g = $urandom_range(gap_max, gap_min);
      if (g > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (g) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b[i];
      if (in_ready !== 1'b1) break;
      chk("core_reset_while_loading", {31'd0, core_reset}, 32'd1);
      @(negedge clk);
      consumed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_image(input string tag, input logic [7:0] b[$], input int gap_min,
                           input int gap_max);
    int exp_cons, outcome, cons;
    model_image(b, exp_cons, outcome);
    drive(b, gap_min, gap_max, cons);
    chk({tag, "_consumed"}, cons, exp_cons);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, outcome == 1});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, outcome == 2});
    chk({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, outcome != 1});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, outcome == 0});
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  function automatic void add_csum(ref logic [7:0] b[$]);
    logic [7:0] x = 8'd0;
    foreach (b[i]) x ^= b[i];
    b.push_back(x);
  endfunction

  initial begin
    logic [7:0] img[$];
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    check_idle("reset");
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("reset_wr_data", {16'd0, wr_data}, 32'd0);

    // nominal load
    run_image("nominal", '{8'h02, 8'h01, 8'h23, 8'h13, 8'h14, 8'h27}, 0, 0);

    // reload from RUN
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_idle("reload");
    run_image("reload_img", '{8'h01, 8'hAB, 8'hCD, 8'h67}, 0, 0);

    // reload and reset together: reset wins, loader idle in HDR
    reload = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    reset  = 1'b0;
    check_idle("reload_reset");

    // bad checksum: words written, then ERR; reload ignored
    run_image("bad_csum", '{8'h02, 8'h01, 8'h23, 8'h13, 8'h14, 8'h26, 8'h55}, 0, 0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
    chk("err_reload_err", {31'd0, err}, 32'd1);
    chk("err_reload_ready", {31'd0, in_ready}, 32'd0);
    do_reset();

    // header bounds
    run_image("hdr_zero", '{8'h00, 8'h01, 8'h02}, 0, 0);
    do_reset();
    run_image("hdr_over", '{8'h11, 8'h01, 8'h02}, 0, 0);
    do_reset();
    img = '{8'h10};
    for (int i = 0; i < 32; i++) img.push_back(8'($urandom));
    add_csum(img);
    run_image("hdr_full", img, 0, 0);
    do_reset();

    // gapped handshake
    run_image("gapped", '{8'h02, 8'h01, 8'h23, 8'h13, 8'h14, 8'h27}, 3, 3);
    do_reset();

    // reset mid-image right after byte 23 is accepted
    run_image("partial", '{8'h02, 8'h01, 8'h23}, 0, 0);
    do_reset();
    check_idle("mid_reset");
    run_image("after_reset", '{8'h02, 8'h01, 8'h23, 8'h13, 8'h14, 8'h27}, 0, 0);
    do_reset();

    // randomized images, sometimes corrupted checksum, random gaps
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(DEPTH, 1);
      img = '{8'(n)};
      for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
      add_csum(img);
      if ($urandom_range(3, 0) == 0) img[img.size() - 1] ^= 8'(1 << $urandom_range(7, 0));
      run_image("random", img, 0, 2);
      if (done === 1'b1 && $urandom_range(1, 0) == 1) begin
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        exp_q.delete();
      end else begin
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
